// File: rtl/mem_class_pkg.sv
// mem_class_pkg
// Shared types for the march test controller and its error map.
//   march_state_t : controller phase (IDLE, W1 sweep, R1 compare,
//                   W0 sweep, R0 compare, DONE)
//   err_t         : 2-bit per-word error class stored in the map
//                   bit 0 = word failed to hold all ones  (stuck-at-0 seen)
//                   bit 1 = word failed to hold all zeros (stuck-at-1 seen)
package mem_class_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        W1   = 3'd1,
        R1   = 3'd2,
        W0   = 3'd3,
        R0   = 3'd4,
        DONE = 3'd5
    } march_state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_SA0   = 2'b01,
        ERR_SA1   = 2'b10,
        ERR_MIXED = 2'b11
    } err_t;

endpackage

// File: rtl/march_controller_error_map.sv
// error_map
// N_WORDS x 2-bit error-class storage for the march controller.
// Ports:
//   clk        : rising-edge clock
//   clear      : synchronous clear of every entry to ERR_NONE (wins over we)
//   we         : write enable for waddr/wdata
//   waddr      : write address
//   wdata      : 2-bit class written at waddr
//   rmw_addr   : combinational read address used for read-modify-write
//   rmw_data   : entry at rmw_addr
//   host_addr  : host read address; addresses >= N_WORDS read as ERR_NONE
//   host_data  : entry at host_addr
module error_map
    import mem_class_pkg::*;
#(
    parameter int N_WORDS = 64,
    parameter int ADDR_W  = $clog2(N_WORDS)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [1:0]        wdata,
    input  logic [ADDR_W-1:0] rmw_addr,
    output logic [1:0]        rmw_data,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [1:0]        host_data
);

    logic [1:0] map_q [N_WORDS];

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < N_WORDS; i++) begin
                map_q[i] <= ERR_NONE;
            end
        end else if (we) begin
            map_q[waddr] <= wdata;
        end
    end

    // The controller never drives rmw_addr past N_WORDS-1.
    assign rmw_data = map_q[rmw_addr];

    // When N_WORDS is not a power of two the host can address past the end.
    always_comb begin
        host_data = ERR_NONE;
        if ({1'b0, host_addr} < (ADDR_W + 1)'(N_WORDS)) begin
            host_data = map_q[host_addr];
        end
    end

endmodule

// File: rtl/march_controller.sv
// march_controller
// Single-engine march test sequencer for a single-port RAM:
// W1 sweep, R1 compare, W0 sweep, R0 compare, then DONE. Both compare
// passes merge into one 2-bit-per-word error map readable by the host.
// Optional build macro: MARCH_FAULT_COUNT_EN adds the fault_words output.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   start        : run request, honoured only in IDLE or DONE
//   busy         : high in W1/R1/W0/R0
//   done         : level, high in DONE
//   mem_we       : RAM write enable (W1/W0 only)
//   mem_addr     : RAM address (= address counter)
//   mem_wdata    : RAM write data ('1 in W1, '0 otherwise)
//   mem_rdata    : RAM read data, combinational from mem_addr
//   rd_addr      : host error-map read address
//   rd_data      : error class at rd_addr (combinational)
//   fault_words  : (MARCH_FAULT_COUNT_EN) words with a non-zero class
//   state_dbg    : current controller state
//
// Handshake: start is a request qualified by (!busy). A start seen in IDLE
// or DONE is accepted on that edge, busy rises and done falls on the same
// edge; start while busy is dropped. The run always ends with busy low and
// done high; done then holds until the next accepted start or reset.
module march_controller
    import mem_class_pkg::*;
#(
    parameter int N_WORDS = 64,
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = $clog2(N_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        rd_data,
`ifdef MARCH_FAULT_COUNT_EN
    output logic [ADDR_W:0]   fault_words,
`endif
    output march_state_t      state_dbg
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

    march_state_t      state;
    logic [ADDR_W-1:0] addr_cnt;
    logic              last_addr;
    logic              accept_start;

    logic              fail1;
    logic              fail0;
    logic              map_we;
    logic [1:0]        map_wdata;
    logic [1:0]        rmw_rd;

    assign last_addr    = (addr_cnt == LAST_ADDR);
    assign accept_start = start && ((state == IDLE) || (state == DONE));
    assign mem_addr     = addr_cnt;
    assign state_dbg    = state;

    // Sequencer: state, counter and all RAM-side outputs are registered
    // together, so outputs always match the phase the counter is in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= W1;
                        addr_cnt  <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        mem_we    <= 1'b1;
                        mem_wdata <= '1;
                    end
                end
                W1: begin
                    if (last_addr) begin
                        state     <= R1;
                        addr_cnt  <= '0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                    end else begin
                        addr_cnt  <= addr_cnt + 1'b1;
                    end
                end
                R1: begin
                    if (last_addr) begin
                        state     <= W0;
                        addr_cnt  <= '0;
                        mem_we    <= 1'b1;
                        mem_wdata <= '0;
                    end else begin
                        addr_cnt  <= addr_cnt + 1'b1;
                    end
                end
                W0: begin
                    if (last_addr) begin
                        state     <= R0;
                        addr_cnt  <= '0;
                        mem_we    <= 1'b0;
                    end else begin
                        addr_cnt  <= addr_cnt + 1'b1;
                    end
                end
                R0: begin
                    if (last_addr) begin
                        state     <= DONE;
                        addr_cnt  <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        addr_cnt  <= addr_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    addr_cnt  <= '0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_wdata <= '0;
                end
            endcase
        end
    end

    assign fail1 = (mem_rdata != '1);
    assign fail0 = (mem_rdata != '0);

    // R1 overwrites the whole entry, so a fresh run needs no pre-clear.
    // R0 keeps the R1 result in bit 0 and adds its own verdict in bit 1.
    always_comb begin
        map_we    = 1'b0;
        map_wdata = ERR_NONE;
        if (state == R1) begin
            map_we    = 1'b1;
            map_wdata = {1'b0, fail1};
        end else if (state == R0) begin
            map_we    = 1'b1;
            map_wdata = {fail0, rmw_rd[0]};
        end
    end

    // Reset doubles as the map clear and wins over any compare write in
    // the same cycle, so an aborted run leaves nothing behind.
    error_map #(
        .N_WORDS (N_WORDS),
        .ADDR_W  (ADDR_W)
    ) u_error_map (
        .clk       (clk),
        .clear     (reset),
        .we        (map_we),
        .waddr     (addr_cnt),
        .wdata     (map_wdata),
        .rmw_addr  (addr_cnt),
        .rmw_data  (rmw_rd),
        .host_addr (rd_addr),
        .host_data (rd_data)
    );

`ifdef MARCH_FAULT_COUNT_EN
    // Counts R0 cycles whose merged entry is non-zero: exactly one per
    // faulty word, since every word is visited once in R0.
    always_ff @(posedge clk) begin
        if (reset || accept_start) begin
            fault_words <= '0;
        end else if (map_we && (state == R0) && (map_wdata != ERR_NONE)) begin
            fault_words <= fault_words + 1'b1;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept_start;
`endif

endmodule
